// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the single RAM port: data accesses win over icache refills,
// fetches can be flushed mid-flight, and stores to the IO region respect io_buffer_full.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_done,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        src_data_q, src_data_d;
  logic        io_q, io_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;

  logic [31:0] asm_word;
  logic [2:0]  wr_idx;
  logic [2:0]  d_n;
  logic        d_io;
  logic        d_stall;

  assign d_io    = (d_addr[17:16] == 2'b11);
  assign d_stall = d_we && d_io && io_buffer_full;
  assign d_n     = (d_size == 2'b00) ? 3'd1 : (d_size == 2'b01) ? 3'd2 : 3'd4;

  // A write slot only counts as done if ram_wr was actually high in it.
  assign wr_idx = idx_q + {2'b00, ram_wr_q};

  // Byte idx-1 arrives on ram_din while idx is in the counter.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [2:0] LANE = 3'(gi + 1);
      assign asm_word[gi*8 +: 8] = (idx_q == LANE) ? ram_din : buf_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    src_data_d = src_data_q;
    io_d       = io_q;
    if_data_d  = if_data_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    ram_addr_d = 32'h0;
    ram_dout_d = 8'h00;
    ram_wr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = 3'd0;
        if (d_req) begin
          // A throttled IO store still holds priority; the fetch keeps waiting.
          if (!d_stall) begin
            src_data_d = 1'b1;
            base_d     = d_addr;
            wdata_d    = d_wdata;
            io_d       = d_io;
            n_d        = d_n;
            buf_d      = 32'h0;
            ram_addr_d = d_addr;
            if (d_we) begin
              state_d    = WRITE;
              ram_dout_d = d_wdata[7:0];
              ram_wr_d   = 1'b1;
            end else begin
              state_d = READ;
            end
          end
        end else if (if_req && !flush) begin
          src_data_d = 1'b0;
          base_d     = if_addr;
          io_d       = 1'b0;
          n_d        = 3'd4;
          buf_d      = 32'h0;
          ram_addr_d = if_addr;
          state_d    = READ;
        end
      end

      READ: begin
        if (!src_data_q && flush) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (idx_q == n_q) begin
          state_d = DONE;
          idx_d   = 3'd0;
          if (src_data_q) begin
            d_rdata_d = asm_word;
            d_done_d  = 1'b1;
          end else begin
            if_data_d = asm_word;
            if_done_d = 1'b1;
          end
        end else begin
          buf_d = asm_word;
          idx_d = idx_q + 3'd1;
          if ((idx_q + 3'd1) < n_q) begin
            ram_addr_d = base_q + {29'b0, idx_q + 3'd1};
          end
        end
      end

      WRITE: begin
        if (wr_idx == n_q) begin
          state_d  = DONE;
          idx_d    = 3'd0;
          d_done_d = 1'b1;
        end else begin
          idx_d      = wr_idx;
          ram_addr_d = base_q + {29'b0, wr_idx};
          ram_dout_d = wdata_q[{wr_idx[1:0], 3'b000} +: 8];
          ram_wr_d   = !(io_q && io_buffer_full);
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      n_q        <= 3'd0;
      base_q     <= 32'h0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      src_data_q <= 1'b0;
      io_q       <= 1'b0;
      if_data_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      ram_addr_q <= 32'h0;
      ram_dout_q <= 8'h00;
      ram_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      src_data_q <= src_data_d;
      io_q       <= io_d;
      if_data_q  <= if_data_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  assign if_data  = if_data_q;
  assign if_done  = if_done_q;
  assign d_rdata  = d_rdata_q;
  assign d_done   = d_done_q;
  assign ram_addr = ram_addr_q;
  assign ram_dout = ram_dout_q;
  assign ram_wr   = ram_wr_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single byte-wide RAM port between instruction fetch (icache miss refill) and the MEM stage's loads and stores. It serialises each access into 1, 2 or 4 byte cycles. Data accesses have fixed priority over fetch, and an in-flight fetch can be aborted on a pipeline flush. Writes to the IO region are throttled by `io_buffer_full`. It sits between `icache`/`mem` and the RAM in `riscv_top`.

## Interface
- No parameters; address width 32, data width 32, RAM data 8.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request, level, held until `if_done` or `flush`.
- `if_addr` in 32: fetch byte address.
- `flush` in 1: abort the pending or in-flight fetch.
- `if_data` out 32: fetched word, little-endian.
- `if_done` out 1: one-cycle pulse; `if_data` is valid in the same cycle.
- `d_req` in 1: data request, level, held until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data; byte 0 = bits [7:0].
- `d_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `d_rdata` out 32: load data, zero-extended (sign extension is done in `mem`).
- `d_done` out 1: one-cycle pulse.
- `ram_din` in 8: RAM read byte; synchronous RAM, valid the cycle after its address.
- `ram_addr` out 32: RAM byte address.
- `ram_dout` out 8: RAM write byte.
- `ram_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: UART buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE.
  - `idx` is a 3-bit byte counter.
  - `n` is the byte count: 1, 2 or 4 for data, always 4 for fetch.
  - Base address, source, `n`, and the write data for stores are latched at acceptance.
- Arbitration, evaluated only in IDLE:
  - If `d_req` is high, the data access is accepted. Stores go to WRITE, loads go to READ.
  - Otherwise, if `if_req` is high and `flush` is low, the fetch is accepted and goes to READ.
  - Otherwise the block stays in IDLE.
  - There is no preemption: a fetch in flight is never interrupted by `d_req`.
- READ:
  - Drive `ram_addr` = base + `idx` while `idx` < `n`.
  - Capture `ram_din` into byte `idx`−1 whenever `idx` ≥ 1.
  - Increment `idx` each cycle.
  - When `idx` == `n`: capture the final byte, move to DONE, and register the assembled word into `if_data` or `d_rdata`.
- WRITE:
  - Drive `ram_addr` = base + `idx`, `ram_dout` = latched byte `idx`, `ram_wr` = 1.
  - Increment `idx` each cycle.
  - After byte `n`−1, move to DONE.
- IO throttle:
  - The IO region is `d_addr[17:16]` == 2'b11.
  - While `io_buffer_full` is high, an IO store is not accepted, and a WRITE to the IO region holds with `ram_wr` = 0 and `idx` frozen.
  - A held IO store does not block nothing else in practice: it keeps priority, so the fetch waits.
- DONE:
  - Pulse `if_done` or `d_done` for the source.
  - Requests are ignored in this cycle, so a requester has one cycle to drop its `req`.
  - Return to IDLE.
- Flush:
  - In READ with source = fetch, `flush` sends the state to IDLE at the next edge with no `if_done`; `if_data` keeps its previous value.
  - `flush` during a data access or in DONE of a data access has no effect.
  - `flush` in DONE of a fetch suppresses nothing; the pulse has already been issued.
- Address arithmetic is 32-bit modulo, so base 0xFFFFFFFF + 1 wraps to 0. Unaligned accesses are legal and are simply consecutive bytes.
- Reset (any state, including mid-access):
  - State goes to IDLE and `idx` to 0.
  - `ram_addr`, `ram_dout`, `ram_wr`, `if_done`, `d_done`, `if_data` and `d_rdata` go to 0.
  - No done pulse is issued for the aborted access.
- Outside READ/WRITE, `ram_addr` = 0, `ram_dout` = 0 and `ram_wr` = 0.

## Timing
- Acceptance edge E0, the IDLE edge where `req` is sampled.
- Read of `n` bytes:
  - Addresses are driven in the cycles after E0 … E(`n`−1).
  - Byte i is captured at edge E(i+2).
  - The done pulse is high in the cycle after E(`n`+1), i.e. `n`+2 cycles after the `req` sample.
  - Word read: done in the 6th cycle counting from the `req` sample.
- Write of `n` bytes:
  - `ram_wr` is high for `n` consecutive cycles after E0, absent an IO stall.
  - Done is high in the cycle after E(`n`).
- Minimum gap between back-to-back accesses: one DONE cycle plus one IDLE sample cycle.
- Registered outputs and `ram_*` change only on `clk` edges; `ram_*` are driven from registered state.

## Test plan
- Reset, then fetch `if_addr`=0x1000 with RAM bytes 13,00,00,EF → `ram_addr` 0x1000..0x1003, one `if_done`, `if_data`=0xEF000013, done 6 cycles after the req sample.
- `d_req` and `if_req` high in the same IDLE cycle; load half at 0x2001 → data served first, `d_rdata`=0x0000BBAA, then the fetch starts after DONE+IDLE.
- Store word 0xDEADBEEF at 0xFFFFFFFE → writes EF,BE,AD,DE to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, `d_done` once.
- Fetch in flight, `flush` raised at `idx`=2 → IDLE next edge, no `if_done`, `if_data` unchanged; `flush` during a data load → load completes normally.
- Byte store to 0x30000 with `io_buffer_full` held high for 3 cycles → no `ram_wr` during the hold, a single write after it drops, then `d_done`.
- `rst` asserted mid-word-store at `idx`=2 → `ram_wr`=0 next cycle, no `d_done`, all outputs 0, and the next request is accepted normally.
